// File: rtl/sync_to_hs_source.sv
// sync_to_hs_source
//   Clocked front end for a self-timed pipeline. Words arrive on a
//   valid/ready interface and are buffered in a small FIFO. Each word is
//   then issued to the first handshake latch as a 4-phase bundled-data
//   transfer. The acknowledge is asynchronous and is synchronised first.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst        : synchronous reset, active-high
//   in_valid   : upstream word valid
//   in_ready   : FIFO can accept a word (not full, not in reset)
//   in_data    : upstream word
//   req_out    : 4-phase request, a plain flop output, high only in REQ
//   ack_out    : 4-phase acknowledge from downstream (asynchronous)
//   data_out   : bundled data, registered; changes only on a pop edge
//   fifo_level : number of words held in the FIFO
//   busy       : handshake FSM is not idle
module sync_to_hs_source #(
  parameter int DATA_W      = 3,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       req_out,
  input  logic                       ack_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int SW = $clog2(SYNC_STAGES+1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SYNC_STAGES);
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;

  state_t                   state, state_next;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [LW-1:0]            count;
  logic [SYNC_STAGES-1:0]   ack_sync;
  logic [SW-1:0]            settle;
  logic                     ack_s;
  logic                     push, pop, empty, full;

  assign ack_s      = ack_sync[SYNC_STAGES-1];
  assign empty      = (count == '0);
  assign full       = (count == FULL_LEVEL);
  assign in_ready   = !full && !rst;
  assign push       = in_valid && in_ready;
  assign fifo_level = count;
  assign busy       = (state != IDLE);

  // Handshake sequencing. A pop loads data_out one full cycle before
  // req_out rises, giving the bundled-data setup margin. After reset the
  // synchroniser holds zeros that do not yet reflect ack_out, so IDLE
  // waits until the chain has refilled with real samples (settle == 0);
  // an acknowledge still held high downstream is then seen and respected.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !ack_s && (settle == '0)) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: state_next = REQ;
      REQ: begin
        if (ack_s) state_next = RELEASE;
      end
      RELEASE: begin
        if (!ack_s) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ack_sync <= '0;
      settle   <= SETTLE_INIT;
    end else begin
      state    <= state_next;
      // Registered straight from the next state: glitch-free, high only in REQ.
      req_out  <= (state_next == REQ);
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_out};
      if (settle != '0) settle <= settle - 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_sync_to_hs_source.sv
module tb_sync_to_hs_source;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 4;
  localparam int SS     = 2;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, req_out, ack_out, busy;
  logic [DATA_W-1:0] in_data, data_out;
  logic [2:0]        fifo_level;

  always #5 clk = ~clk;

  sync_to_hs_source #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .req_out(req_out), .ack_out(ack_out),
    .data_out(data_out), .fifo_level(fifo_level), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: word queue plus a description of the current transfer
  // (word held, setup pending, request raised) and the ack seen through SS flops.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_data;
  bit                m_holding, m_setup, m_req;
  bit                m_sync[SS];
  int                m_settle;

  // End-to-end scoreboard: words accepted but not yet presented with a request.
  logic [DATA_W-1:0] sb_q[$];

  logic              prev_req = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  int                rise_cnt = 0;

  bit resp_en = 1'b0;
  int pend = 0;
  int max_dly = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ack_seen;
    bit do_pop;
    bit do_push;
    ack_seen = m_sync[SS-1];
    do_push  = in_valid && !rst && (m_q.size() < DEPTH);
    do_pop   = 1'b0;
    if (rst) begin
      m_q.delete();
      sb_q.delete();
      m_data    = '0;
      m_holding = 1'b0;
      m_setup   = 1'b0;
      m_req     = 1'b0;
      for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
      m_settle  = SS;
    end else begin
      if (!m_holding) begin
        if (m_q.size() > 0 && !ack_seen && m_settle == 0) begin
          do_pop = 1'b1; m_holding = 1'b1; m_setup = 1'b1;
        end
      end else if (m_setup) begin
        m_setup = 1'b0; m_req = 1'b1;
      end else if (m_req) begin
        if (ack_seen) m_req = 1'b0;
      end else if (!ack_seen) begin
        if (m_q.size() > 0) begin
          do_pop = 1'b1; m_setup = 1'b1;
        end else begin
          m_holding = 1'b0;
        end
      end
      if (do_pop) m_data = m_q.pop_front();
      if (do_push) begin
        m_q.push_back(in_data);
        sb_q.push_back(in_data);
      end
      for (int i = SS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = ack_out;
      if (m_settle > 0) m_settle--;
    end
  endtask

  task automatic step();
    int sz;
    @(posedge clk);
    model_edge();
    #1;
    sz = m_q.size();
    check("req_out", {31'd0, req_out}, {31'd0, m_req});
    check("data_out", {29'd0, data_out}, {29'd0, m_data});
    check("fifo_level", {29'd0, fifo_level}, sz);
    check("busy", {31'd0, busy}, {31'd0, m_holding});
    check("in_ready", {31'd0, in_ready}, {31'd0, (!rst && sz < DEPTH)});
    if (prev_req && !rst) check("data_hold_req", {29'd0, data_out}, {29'd0, prev_data});
    if (req_out && !prev_req) begin
      rise_cnt++;
      check("data_setup", {29'd0, data_out}, {29'd0, prev_data});
      if (sb_q.size() == 0) check("order_nonempty", 0, 1);
      else check("order", {29'd0, data_out}, {29'd0, sb_q.pop_front()});
    end
    prev_req  = req_out;
    prev_data = data_out;
    if (resp_en && (req_out !== ack_out)) begin
      if (pend == 0) pend = (max_dly <= 1) ? 1 : $urandom_range(max_dly, 1);
      pend--;
      if (pend == 0) ack_out = req_out;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (!busy && fifo_level == 0) done = 1'b1;
    end
    check(name, {31'd0, done}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rises0;
    bit found;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ack_out = 1'b0;
    step(); step();
    check("rst_req", {31'd0, req_out}, 0);
    check("rst_data", {29'd0, data_out}, 0);
    check("rst_level", {29'd0, fifo_level}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    rst = 1'b0;
    step(); step(); step();
    check("ready_after_rst", {31'd0, in_ready}, 1);

    // Single word, responder with one cycle of delay.
    resp_en = 1'b1; max_dly = 1; rises0 = rise_cnt;
    in_valid = 1'b1; in_data = 3'b101;
    step();                                   // edge N: push
    in_valid = 1'b0;
    check("t1_level_N", {29'd0, fifo_level}, 1);
    step();                                   // N+1: pop
    check("t1_data_N1", {29'd0, data_out}, 5);
    check("t1_req_N1", {31'd0, req_out}, 0);
    check("t1_busy_N1", {31'd0, busy}, 1);
    step();                                   // N+2: request
    check("t1_req_N2", {31'd0, req_out}, 1);
    step(); step(); step();                   // N+5: ack seen, release
    check("t1_req_N5", {31'd0, req_out}, 0);
    check("t1_data_N5", {29'd0, data_out}, 5);
    step(); step();                           // N+7
    check("t1_busy_N7", {31'd0, busy}, 1);
    step();                                   // N+8: idle
    check("t1_busy_N8", {31'd0, busy}, 0);
    check("t1_one_transfer", rise_cnt - rises0, 1);

    // Burst with the acknowledge held low: FIFO fills behind one open request.
    resp_en = 1'b0; ack_out = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = DATA_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    check("t2_level_full", {29'd0, fifo_level}, 4);
    check("t2_in_ready", {31'd0, in_ready}, 0);
    check("t2_req_waiting", {31'd0, req_out}, 1);
    resp_en = 1'b1; max_dly = 3;
    wait_idle(400, "t2_drain");

    // Full-rate pushing against a randomly slow responder.
    max_dly = 7; in_valid = 1'b1;
    for (int i = 0; i < 150; i++) begin
      in_data = DATA_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    wait_idle(800, "t3_drain");
    check("t3_all_delivered", sb_q.size(), 0);

    // Reset in the middle of a transfer with the acknowledge high.
    max_dly = 4; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DATA_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (req_out && ack_out) found = 1'b1;
      else step();
    end
    check("t4_req_ack_high", {31'd0, found}, 1);
    rst = 1'b1; resp_en = 1'b0; ack_out = 1'b1; pend = 0;
    step();
    check("t4_req_dropped", {31'd0, req_out}, 0);
    check("t4_level_cleared", {29'd0, fifo_level}, 0);
    check("t4_ready_in_rst", {31'd0, in_ready}, 0);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 3'd6;
    step();
    in_valid = 1'b0;
    check("t4_queued", {29'd0, fifo_level}, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_idle_while_ack", {31'd0, busy}, 0);
    end
    ack_out = 1'b0; resp_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (busy) found = 1'b1;
    end
    check("t4_starts_after_ack_low", {31'd0, found}, 1);
    check("t4_data", {29'd0, data_out}, 6);
    wait_idle(100, "t4_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
